// File: rtl/load_store_unit_if.sv
// Execute-stage request, data-memory and writeback response bundle of the load/store unit.
// Latency: none, wires only.
// Backpressure: req_ready on the request side, mem_gnt/mem_rvalid on the memory side.
interface load_store_unit_if #(
    parameter int XLEN = 32
);
    // request from execute stage
    logic            req_valid;
    logic            req_ready;
    logic            is_store;
    logic [2:0]      trunc_src;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] store_data;
    logic [4:0]      rd;
    logic            stall;
    // data memory port
    logic            mem_req;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [3:0]      mem_be;
    logic            mem_gnt;
    logic            mem_rvalid;
    logic [XLEN-1:0] mem_rdata;
    // writeback response
    logic            resp_valid;
    logic            resp_we;
    logic            resp_fault;
    logic [XLEN-1:0] resp_data;
    logic [4:0]      resp_rd;

    // the pipeline plus memory model side
    modport master (
        output req_valid, is_store, trunc_src, addr, store_data, rd,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  req_ready, stall, mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  resp_valid, resp_we, resp_fault, resp_data, resp_rd
    );

    // the load/store unit side
    modport slave (
        input  req_valid, is_store, trunc_src, addr, store_data, rd,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output req_ready, stall, mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output resp_valid, resp_we, resp_fault, resp_data, resp_rd
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: one memory op at a time, byte/half lane steering and load extension.
// Latency: load >= 3 cycles, store >= 2 cycles from accept; a trapped misaligned op responds next cycle.
// Backpressure: req_ready only in IDLE; waits indefinitely on mem_gnt/mem_rvalid. Option: MISALIGNED_TRAP_EN.
module load_store_unit #(
    parameter int XLEN = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    load_store_unit_if.slave   bus
);
    localparam logic [2:0] T_BYTE   = 3'd0;
    localparam logic [2:0] T_HALF   = 3'd1;
    localparam logic [2:0] T_BYTE_U = 3'd3;
    localparam logic [2:0] T_HALF_U = 3'd4;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t          state;
    logic            st_q;
    logic [2:0]      ts_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [4:0]      rd_q;
    logic            fault_q;
    logic [XLEN-1:0] data_q;

    logic            is_byte;
    logic            is_half;
    logic [1:0]      off;
    logic [3:0]      be_c;
    logic [XLEN-1:0] wdata_c;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] ext_c;
    logic            mis_c;

    // lane steering from the latched request; misaligned halves/words align down to their own size
    always_comb begin
        is_byte = (ts_q == T_BYTE) || (ts_q == T_BYTE_U);
        is_half = (ts_q == T_HALF) || (ts_q == T_HALF_U);
        off     = 2'b00;
        be_c    = 4'b1111;
        wdata_c = wdata_q;
        if (is_byte) begin
            off     = addr_q[1:0];
            be_c    = 4'b0001 << addr_q[1:0];
            wdata_c = {4{wdata_q[7:0]}};
        end else if (is_half) begin
            off     = {addr_q[1], 1'b0};
            be_c    = 4'b0011 << {addr_q[1], 1'b0};
            wdata_c = {2{wdata_q[15:0]}};
        end
    end

    // shift the read word down to the addressed lane, then sign/zero extend
    always_comb begin
        shifted = bus.mem_rdata >> {off, 3'b000};
        case (ts_q)
            T_BYTE:   ext_c = {{24{shifted[7]}}, shifted[7:0]};
            T_HALF:   ext_c = {{16{shifted[15]}}, shifted[15:0]};
            T_BYTE_U: ext_c = {24'd0, shifted[7:0]};
            T_HALF_U: ext_c = {16'd0, shifted[15:0]};
            default:  ext_c = shifted;
        endcase
    end

    // misalignment of the incoming request, only ever set when trapping is built in
    always_comb begin
        mis_c = 1'b0;
`ifdef MISALIGNED_TRAP_EN
        if ((bus.trunc_src == T_HALF) || (bus.trunc_src == T_HALF_U))
            mis_c = bus.addr[0];
        else if ((bus.trunc_src != T_BYTE) && (bus.trunc_src != T_BYTE_U))
            mis_c = (bus.addr[1:0] != 2'b00);
`endif
    end

    // transaction FSM; reset abandons any outstanding memory op
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            st_q    <= 1'b0;
            ts_q    <= 3'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= 5'd0;
            fault_q <= 1'b0;
            data_q  <= '0;
        end else begin
            case (state)
                IDLE: if (bus.req_valid) begin
                    st_q    <= bus.is_store;
                    ts_q    <= bus.trunc_src;
                    addr_q  <= bus.addr;
                    wdata_q <= bus.store_data;
                    rd_q    <= bus.rd;
                    fault_q <= mis_c;
                    data_q  <= '0;
                    state   <= mis_c ? RESP : REQ;
                end
                REQ: if (bus.mem_gnt) begin
                    state <= st_q ? RESP : WAIT;
                end
                WAIT: if (bus.mem_rvalid) begin
                    data_q <= ext_c;
                    state  <= RESP;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // outputs decode the state register and the latched request, so they hold steady through REQ
    assign bus.req_ready  = (state == IDLE);
    assign bus.stall      = (state != IDLE);
    assign bus.mem_req    = (state == REQ);
    assign bus.mem_we     = (state == REQ) && st_q;
    assign bus.mem_addr   = (state == REQ) ? {addr_q[XLEN-1:2], 2'b00} : '0;
    assign bus.mem_be     = (state == REQ) ? be_c : 4'b0000;
    assign bus.mem_wdata  = ((state == REQ) && st_q) ? wdata_c : '0;
    assign bus.resp_valid = (state == RESP);
    assign bus.resp_we    = (state == RESP) && !st_q && !fault_q;
    assign bus.resp_data  = (state == RESP) ? data_q : '0;
    assign bus.resp_rd    = bus.resp_we ? rd_q : 5'd0;
`ifdef MISALIGNED_TRAP_EN
    assign bus.resp_fault = (state == RESP) && fault_q;
`else
    assign bus.resp_fault = 1'b0;
`endif
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed ops, expected responses queued and checked by a monitor.
// Latency of each response is checked against the minimum plus injected grant delay.
// Memory side is driven by the stimulus task (grant delay per vector, rvalid one cycle after grant).
module tb_load_store_unit;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    load_store_unit_if #(.XLEN(32)) bus ();

    load_store_unit #(.XLEN(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

`ifdef MISALIGNED_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    typedef struct {
        logic [31:0] data;
        logic        we;
        logic [4:0]  rd;
        logic        fault;
        int          acc;
        int          lat;
        int          id;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int op_id = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s (op %0d) actual=%h expected=%h", nm, id, act, exp);
        end
    endtask

    // monitor: every response strobe must match the oldest queued expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.resp_valid === 1'b1) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_resp actual=resp_valid=1 expected=no response");
                end else begin
                    e = q.pop_front();
                    chk("resp_data", e.id, bus.resp_data, e.data);
                    chk("resp_we", e.id, 32'(bus.resp_we), 32'(e.we));
                    chk("resp_rd", e.id, 32'(bus.resp_rd), 32'(e.rd));
                    chk("resp_fault", e.id, 32'(bus.resp_fault), 32'(e.fault));
                    chk("latency", e.id, 32'(cyc - e.acc + 1), 32'(e.lat));
                end
            end
        end
    end

    task automatic op(input logic st, input logic [2:0] ts, input logic [31:0] a,
                      input logic [31:0] wd, input logic [4:0] r, input int gdly,
                      input logic [31:0] rdata, input logic [31:0] e_addr, input logic [3:0] e_be,
                      input logic [31:0] e_wdata, input logic [31:0] e_data, input logic e_fault);
        exp_t e;
        int n;
        op_id++;
        @(negedge clk);
        chk("req_ready", op_id, 32'(bus.req_ready), 32'd1);
        bus.is_store   = st;
        bus.trunc_src  = ts;
        bus.addr       = a;
        bus.store_data = wd;
        bus.rd         = r;
        bus.req_valid  = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid  = 1'b0;
        e.data  = e_fault ? 32'd0 : e_data;
        e.we    = !st && !e_fault;
        e.rd    = (!st && !e_fault) ? r : 5'd0;
        e.fault = e_fault;
        e.acc   = cyc;
        e.lat   = e_fault ? 1 : (st ? 2 + gdly : 3 + gdly);
        e.id    = op_id;
        q.push_back(e);
        if (e_fault) begin
            repeat (3) begin
                @(negedge clk);
                chk("mem_req_trapped", op_id, 32'(bus.mem_req), 32'd0);
            end
        end else begin
            for (int k = 0; k <= gdly; k++) begin
                @(negedge clk);
                chk("mem_req", op_id, 32'(bus.mem_req), 32'd1);
                chk("stall", op_id, 32'(bus.stall), 32'd1);
                chk("mem_addr", op_id, bus.mem_addr, e_addr);
                chk("mem_be", op_id, 32'(bus.mem_be), 32'(e_be));
                chk("mem_we", op_id, 32'(bus.mem_we), 32'(st));
                if (st) chk("mem_wdata", op_id, bus.mem_wdata, e_wdata);
                if (k == gdly) bus.mem_gnt = 1'b1;
            end
            @(posedge clk);
            #1;
            bus.mem_gnt = 1'b0;
            if (!st) begin
                @(negedge clk);
                chk("mem_req_wait", op_id, 32'(bus.mem_req), 32'd0);
                chk("stall_wait", op_id, 32'(bus.stall), 32'd1);
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata  = rdata;
                @(posedge clk);
                #1;
                bus.mem_rvalid = 1'b0;
                bus.mem_rdata  = 32'd0;
            end
        end
        n = 0;
        while (q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL resp_timeout (op %0d) actual=no response expected=resp_valid", op_id);
            q.delete();
        end
    endtask

    initial begin
        bus.req_valid  = 1'b0;
        bus.is_store   = 1'b0;
        bus.trunc_src  = 3'd0;
        bus.addr       = 32'd0;
        bus.store_data = 32'd0;
        bus.rd         = 5'd0;
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'd0;
        #2;
        // reset values
        chk("rst_req_ready", 0, 32'(bus.req_ready), 32'd1);
        chk("rst_stall", 0, 32'(bus.stall), 32'd0);
        chk("rst_mem_req", 0, 32'(bus.mem_req), 32'd0);
        chk("rst_resp_valid", 0, 32'(bus.resp_valid), 32'd0);
        chk("rst_mem_be", 0, 32'(bus.mem_be), 32'd0);
        chk("rst_resp_data", 0, bus.resp_data, 32'd0);
        #10;
        reset_n = 1'b1;

        //  st  ts    addr          wdata         rd  gdly rdata         e_addr        be     e_wdata       e_data        fault
        op(0, 3'd2, 32'h0000_0100, 32'h0,        5'd5,  0, 32'hDEADBEEF, 32'h0000_0100, 4'hF, 32'h0,        32'hDEADBEEF, 1'b0);
        op(0, 3'd0, 32'h0000_0103, 32'h0,        5'd6,  0, 32'h80112233, 32'h0000_0100, 4'h8, 32'h0,        32'hFFFFFF80, 1'b0);
        op(0, 3'd3, 32'h0000_0103, 32'h0,        5'd6,  0, 32'h80112233, 32'h0000_0100, 4'h8, 32'h0,        32'h00000080, 1'b0);
        op(1, 3'd1, 32'h0000_0202, 32'h0000ABCD, 5'd7,  4, 32'h0,        32'h0000_0200, 4'hC, 32'hABCDABCD, 32'h0,        1'b0);
        op(0, 3'd1, 32'h0000_0101, 32'h0,        5'd8,  0, 32'h80112233, 32'h0000_0100, 4'h3, 32'h0,        32'h00002233, TRAP);
        op(0, 3'd4, 32'h0000_0102, 32'h0,        5'd9,  1, 32'h80112233, 32'h0000_0100, 4'hC, 32'h0,        32'h00008011, 1'b0);
        op(0, 3'd1, 32'h0000_0202, 32'h0,        5'd10, 0, 32'h80011234, 32'h0000_0200, 4'hC, 32'h0,        32'hFFFF8001, 1'b0);
        op(1, 3'd0, 32'h0000_0301, 32'hFFFFFF5A, 5'd1,  1, 32'h0,        32'h0000_0300, 4'h2, 32'h5A5A5A5A, 32'h0,        1'b0);
        op(1, 3'd2, 32'h0000_0400, 32'h12345678, 5'd3,  0, 32'h0,        32'h0000_0400, 4'hF, 32'h12345678, 32'h0,        1'b0);
        op(0, 3'd2, 32'h0000_0106, 32'h0,        5'd11, 0, 32'h11223344, 32'h0000_0104, 4'hF, 32'h0,        32'h11223344, TRAP);
        op(0, 3'd5, 32'h0000_0108, 32'h0,        5'd12, 2, 32'hCAFEF00D, 32'h0000_0108, 4'hF, 32'h0,        32'hCAFEF00D, 1'b0);
        op(0, 3'd3, 32'h0000_0101, 32'h0,        5'd13, 0, 32'h80112233, 32'h0000_0100, 4'h2, 32'h0,        32'h00000022, 1'b0);
        op(1, 3'd4, 32'h0000_0200, 32'h1234BEEF, 5'd14, 0, 32'h0,        32'h0000_0200, 4'h3, 32'hBEEFBEEF, 32'h0,        1'b0);

        // reset in WAIT, then a stray rvalid must be ignored
        @(negedge clk);
        bus.is_store  = 1'b0;
        bus.trunc_src = 3'd2;
        bus.addr      = 32'h0000_0100;
        bus.rd        = 5'd4;
        bus.req_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        bus.mem_gnt = 1'b1;
        @(posedge clk);
        #1;
        bus.mem_gnt = 1'b0;
        @(negedge clk);
        chk("wait_stall", 99, 32'(bus.stall), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("arst_req_ready", 99, 32'(bus.req_ready), 32'd1);
        chk("arst_stall", 99, 32'(bus.stall), 32'd0);
        chk("arst_mem_req", 99, 32'(bus.mem_req), 32'd0);
        chk("arst_resp_valid", 99, 32'(bus.resp_valid), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'd0;
        repeat (3) begin
            @(negedge clk);
            chk("stray_resp_valid", 99, 32'(bus.resp_valid), 32'd0);
            chk("stray_req_ready", 99, 32'(bus.req_ready), 32'd1);
        end

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: XLEN, 32, data and address width; only 32 is supported.
REQ-002 Port: clk  input  1  sole clock; all state on rising edge.
REQ-003 Port: reset_n  input  1  asynchronous active-low reset.
REQ-004 Port: req_valid  input  1  execute stage presents a memory operation.
REQ-005 Port: req_ready  output  1  unit can accept an operation (state IDLE).
REQ-006 Port: is_store  input  1  1 = store, 0 = load.
REQ-007 Port: trunc_src  input  3  truncSrc encoding: BYTE=0, HALF_WORD=1, WORD=2, BYTE_UNSIGNED=3, HALF_WORD_UNSIGNED=4, NO_TRUNC=5.
REQ-008 Port: addr  input  32  byte address from ALU.
REQ-009 Port: store_data  input  32  rs2 value, store data in low bits.
REQ-010 Port: rd  input  5  load destination register.
REQ-011 Port: stall  output  1  high whenever state is not IDLE.
REQ-012 Port: mem_req / mem_we  output  1 / 1  data-memory request and write strobe.
REQ-013 Port: mem_addr  output  32  word-aligned address, bits [1:0] = 0.
REQ-014 Port: mem_wdata / mem_be  output  32 / 4  lane-replicated store data and byte enables.
REQ-015 Port: mem_gnt / mem_rvalid  input  1 / 1  request accepted / read data valid.
REQ-016 Port: mem_rdata  input  32  read word.
REQ-017 Port: resp_valid / resp_we / resp_fault  output  1 / 1 / 1  response strobe, register-write enable, misalignment fault.
REQ-018 Port: resp_data / resp_rd  output  32 / 5  extended load data, destination register.

Function
REQ-019 FSM states IDLE, REQ, WAIT, RESP; req_ready SHALL equal (state == IDLE).
REQ-020 On req_valid && req_ready, all request fields SHALL be latched and the state SHALL go to REQ (or RESP on a trapped misalignment).
REQ-021 In REQ: mem_req=1; stay until mem_gnt; then load -> WAIT, store -> RESP.
REQ-022 In WAIT: stay until mem_rvalid; capture the extended data and go to RESP; mem_rvalid SHALL be ignored outside WAIT.
REQ-023 In RESP: resp_valid=1 for exactly one cycle, then IDLE; minimum latency is 3 cycles for a load and 2 cycles for a store, measured from the accept edge.
REQ-024 Byte enables: byte types 4'b0001<<addr[1:0]; half types 4'b0011<<{addr[1],1'b0}; WORD/NO_TRUNC 4'b1111.
REQ-025 mem_wdata: byte replicated x4, half replicated x2, word unchanged.
REQ-026 Load data SHALL be mem_rdata>>(8*addr[1:0]), then sign-extended (BYTE, HALF_WORD) or zero-extended (BYTE_UNSIGNED, HALF_WORD_UNSIGNED); WORD and NO_TRUNC SHALL pass 32 bits.
REQ-027 Load response: resp_we=1 and resp_rd=latched rd; store response: resp_we=0, resp_data=0, resp_rd=0.
REQ-028 mem_addr, mem_we, mem_wdata and mem_be SHALL be stable from entry to REQ until the gnt cycle.

Reset
REQ-029 reset_n low SHALL immediately force IDLE and drive every output to 0, except req_ready, which SHALL be 1.
REQ-030 Reset in REQ or WAIT SHALL abandon the transaction; a later mem_gnt or mem_rvalid SHALL have no effect.

Configuration
REQ-031 Macro MISALIGNED_TRAP_EN defined: a half access with addr[0]=1 or a word access with addr[1:0]!=0 SHALL skip memory, go directly to RESP, and respond with resp_fault=1, resp_we=0, resp_data=0.
REQ-032 Macro undefined: resp_fault SHALL be tied 0; misaligned half and word accesses SHALL be performed at the address aligned down to their own size.

Verification
REQ-033 Aligned LW at 0x100, gnt same cycle, rvalid +1 with rdata 0xDEADBEEF -> mem_be=1111, resp_data=0xDEADBEEF, resp_valid on the 3rd cycle after accept.
REQ-034 LB at 0x103, rdata 0x80112233 -> mem_be=1000, resp_data=0xFFFFFF80; same access as LBU -> 0x00000080.
REQ-035 SH of 0x0000ABCD at 0x202, gnt delayed 4 cycles -> mem_addr=0x200, mem_be=1100, mem_wdata=0xABCDABCD held stable, stall high throughout, resp_we=0.
REQ-036 LH at 0x101 -> with MISALIGNED_TRAP_EN: mem_req never asserts, resp_fault=1; without it: mem_be=0011, access to 0x100.
REQ-037 reset_n pulsed low in WAIT, then a stray mem_rvalid -> state IDLE, resp_valid stays 0, req_ready=1.
